// File: rtl/ifetch_warp_sched.sv
// Round-robin fetch scheduler owning per-warp PC/mask/state; one registered request, visible one cycle after a warp becomes eligible.
// A held request (valid & ~ready) freezes the request outputs and all selection state until it is accepted.
module ifetch_warp_sched #(
    parameter int               NUM_WARPS   = 4,
    parameter int               NUM_THREADS = 4,
    parameter int               XLEN        = 32,
    parameter int               UUID_BITS   = 44,
    parameter logic [XLEN-1:0]  STARTUP_PC  = 32'h80000000,
    parameter int               NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   spawn_valid,
    input  logic [NW_BITS-1:0]     spawn_wid,
    input  logic [NUM_THREADS-1:0] spawn_tmask,
    input  logic [XLEN-1:0]        spawn_pc,

    input  logic                   rsp_valid,
    input  logic [NW_BITS-1:0]     rsp_wid,
    input  logic                   rsp_stall,

    input  logic                   resume_valid,
    input  logic [NW_BITS-1:0]     resume_wid,
    input  logic [XLEN-1:0]        resume_pc,
    input  logic [NUM_THREADS-1:0] resume_tmask,

    output logic                   ifetch_req_valid,
    output logic [UUID_BITS-1:0]   ifetch_req_uuid,
    output logic [NUM_THREADS-1:0] ifetch_req_tmask,
    output logic [NW_BITS-1:0]     ifetch_req_wid,
    output logic [XLEN-1:0]        ifetch_req_PC,
    input  logic                   ifetch_req_ready,

    output logic [NUM_WARPS-1:0]   active_warps,
    output logic                   busy
);

    logic [NUM_WARPS-1:0]   active_q, active_d;
    logic [NUM_WARPS-1:0]   pending_q, pending_d;
    logic [NUM_WARPS-1:0]   parked_q, parked_d;
    logic [XLEN-1:0]        pc_q    [NUM_WARPS];
    logic [XLEN-1:0]        pc_d    [NUM_WARPS];
    logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
    logic [NUM_THREADS-1:0] tmask_d [NUM_WARPS];

    logic [UUID_BITS-1:0]   uuid_q;
    logic [NW_BITS-1:0]     ptr_q;

    logic                   req_valid_q;
    logic [UUID_BITS-1:0]   req_uuid_q;
    logic [NUM_THREADS-1:0] req_tmask_q;
    logic [NW_BITS-1:0]     req_wid_q;
    logic [XLEN-1:0]        req_pc_q;

    logic [NUM_WARPS-1:0]   eligible;
    logic                   load;
    logic                   pick_found;
    logic [NW_BITS-1:0]     pick_wid;
    logic [NW_BITS-1:0]     ptr_next;
    logic                   issue;

    function automatic logic [NW_BITS-1:0] rr_index(input logic [NW_BITS-1:0] base, input int off);
        int idx;
        idx = int'(base) + off;
        if (idx >= NUM_WARPS) idx = idx - NUM_WARPS;
        return NW_BITS'(idx);
    endfunction

    assign eligible = active_q & ~pending_q & ~parked_q;
    assign load     = ~req_valid_q | ifetch_req_ready;
    assign issue    = load & pick_found;

    // Scan from the farthest offset down so the closest eligible warp to the pointer wins.
    always_comb begin
        pick_found = 1'b0;
        pick_wid   = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (eligible[rr_index(ptr_q, i)]) begin
                pick_found = 1'b1;
                pick_wid   = rr_index(ptr_q, i);
            end
        end
    end

    assign ptr_next = (pick_wid == NW_BITS'(NUM_WARPS - 1)) ? '0 : pick_wid + NW_BITS'(1);

    // Later assignments override earlier ones: resume > rsp > spawn > issue.
    always_comb begin
        active_d  = active_q;
        pending_d = pending_q;
        parked_d  = parked_q;
        for (int w = 0; w < NUM_WARPS; w++) begin
            pc_d[w]    = pc_q[w];
            tmask_d[w] = tmask_q[w];
        end

        if (issue) begin
            pending_d[pick_wid] = 1'b1;
            pc_d[pick_wid]      = pc_q[pick_wid] + XLEN'(4);
        end

        if (spawn_valid && !active_q[spawn_wid] && (spawn_tmask != '0)) begin
            active_d[spawn_wid]  = 1'b1;
            pending_d[spawn_wid] = 1'b0;
            parked_d[spawn_wid]  = 1'b0;
            pc_d[spawn_wid]      = spawn_pc;
            tmask_d[spawn_wid]   = spawn_tmask;
        end

        if (rsp_valid && pending_q[rsp_wid]) begin
            pending_d[rsp_wid] = 1'b0;
            if (rsp_stall) parked_d[rsp_wid] = 1'b1;
        end

        if (resume_valid) begin
            parked_d[resume_wid] = 1'b0;
            pc_d[resume_wid]     = resume_pc;
            tmask_d[resume_wid]  = resume_tmask;
            if (resume_tmask == '0) active_d[resume_wid] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active_q    <= NUM_WARPS'(1);
            pending_q   <= '0;
            parked_q    <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w]    <= (w == 0) ? STARTUP_PC : '0;
                tmask_q[w] <= (w == 0) ? {NUM_THREADS{1'b1}} : '0;
            end
            uuid_q      <= '0;
            ptr_q       <= '0;
            req_valid_q <= 1'b0;
            req_uuid_q  <= '0;
            req_tmask_q <= '0;
            req_wid_q   <= '0;
            req_pc_q    <= '0;
        end else begin
            active_q  <= active_d;
            pending_q <= pending_d;
            parked_q  <= parked_d;
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w]    <= pc_d[w];
                tmask_q[w] <= tmask_d[w];
            end
            if (load) begin
                if (pick_found) begin
                    req_valid_q <= 1'b1;
                    req_uuid_q  <= uuid_q;
                    req_tmask_q <= tmask_q[pick_wid];
                    req_wid_q   <= pick_wid;
                    req_pc_q    <= pc_q[pick_wid];
                    uuid_q      <= uuid_q + UUID_BITS'(1);
                    ptr_q       <= ptr_next;
                end else begin
                    req_valid_q <= 1'b0;
                end
            end
        end
    end

    assign ifetch_req_valid = req_valid_q;
    assign ifetch_req_uuid  = req_uuid_q;
    assign ifetch_req_tmask = req_tmask_q;
    assign ifetch_req_wid   = req_wid_q;
    assign ifetch_req_PC    = req_pc_q;

    assign active_warps = active_q;
    assign busy         = |active_q;

endmodule

// File: tb/tb_ifetch_warp_sched.sv
module tb_ifetch_warp_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        spawn_valid = 1'b0;
    logic [1:0]  spawn_wid = '0;
    logic [3:0]  spawn_tmask = '0;
    logic [31:0] spawn_pc = '0;
    logic        rsp_valid = 1'b0;
    logic [1:0]  rsp_wid = '0;
    logic        rsp_stall = 1'b0;
    logic        resume_valid = 1'b0;
    logic [1:0]  resume_wid = '0;
    logic [31:0] resume_pc = '0;
    logic [3:0]  resume_tmask = '0;
    logic        ifetch_req_valid;
    logic [43:0] ifetch_req_uuid;
    logic [3:0]  ifetch_req_tmask;
    logic [1:0]  ifetch_req_wid;
    logic [31:0] ifetch_req_PC;
    logic        ifetch_req_ready = 1'b1;
    logic [3:0]  active_warps;
    logic        busy;

    int n_chk = 0;
    int n_pass = 0;

    ifetch_warp_sched dut (
        .clk              (clk),
        .reset            (reset),
        .spawn_valid      (spawn_valid),
        .spawn_wid        (spawn_wid),
        .spawn_tmask      (spawn_tmask),
        .spawn_pc         (spawn_pc),
        .rsp_valid        (rsp_valid),
        .rsp_wid          (rsp_wid),
        .rsp_stall        (rsp_stall),
        .resume_valid     (resume_valid),
        .resume_wid       (resume_wid),
        .resume_pc        (resume_pc),
        .resume_tmask     (resume_tmask),
        .ifetch_req_valid (ifetch_req_valid),
        .ifetch_req_uuid  (ifetch_req_uuid),
        .ifetch_req_tmask (ifetch_req_tmask),
        .ifetch_req_wid   (ifetch_req_wid),
        .ifetch_req_PC    (ifetch_req_PC),
        .ifetch_req_ready (ifetch_req_ready),
        .active_warps     (active_warps),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_req(input string tag, input logic [1:0] wid, input logic [31:0] pc,
                             input logic [3:0] tm, input logic [43:0] uuid);
        check({tag, "_valid"}, 64'(ifetch_req_valid), 64'(1));
        check({tag, "_wid"},   64'(ifetch_req_wid),   64'(wid));
        check({tag, "_pc"},    64'(ifetch_req_PC),    64'(pc));
        check({tag, "_tmask"}, 64'(ifetch_req_tmask), 64'(tm));
        check({tag, "_uuid"},  64'(ifetch_req_uuid),  64'(uuid));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rsp(input logic [1:0] wid, input logic stall);
        rsp_valid = 1'b1;
        rsp_wid   = wid;
        rsp_stall = stall;
        step();
        rsp_valid = 1'b0;
        rsp_stall = 1'b0;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        spawn_valid  = 1'b0;
        rsp_valid    = 1'b0;
        resume_valid = 1'b0;
        step();
        step();
    endtask

    // Expected issue stream for the round-robin / park / deactivate sequence; uuid equals the index.
    logic [1:0]  t_wid   [17] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 2, 0, 1, 2, 0, 1, 2};
    logic [31:0] t_pc    [17] = '{32'h80000000, 32'h100, 32'h200, 32'h80000004, 32'h104, 32'h204,
                                  32'h80000008, 32'h108, 32'h208, 32'h8000000C, 32'h20C,
                                  32'h80000010, 32'h400, 32'h210, 32'h80000014, 32'h404, 32'h214};
    logic [3:0]  t_tm    [17] = '{4'hF, 4'h3, 4'h3, 4'hF, 4'h3, 4'h3, 4'hF, 4'h3, 4'h3, 4'hF, 4'h3,
                                  4'hF, 4'h1, 4'h3, 4'hF, 4'h1, 4'h3};
    logic        t_stall [17] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic        t_res   [17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1};
    logic [1:0]  t_rwid  [17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2};
    logic [31:0] t_rpc   [17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h400, 0, 0, 0, 0, 0, 0};
    logic [3:0]  t_rtm   [17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h1, 0, 0, 0, 0, 0, 0};

    initial begin
        // Reset state and first request
        ifetch_req_ready = 1'b1;
        do_reset();
        check("rst_valid",  64'(ifetch_req_valid), 64'(0));
        check("rst_uuid",   64'(ifetch_req_uuid),  64'(0));
        check("rst_pc",     64'(ifetch_req_PC),    64'(0));
        check("rst_tmask",  64'(ifetch_req_tmask), 64'(0));
        check("rst_active", 64'(active_warps),     64'(4'b0001));
        check("rst_busy",   64'(busy),             64'(1));
        reset = 1'b1;
        step();
        check_req("first", 2'd0, 32'h80000000, 4'hF, 44'd0);
        step();
        check("one_inflight_a", 64'(ifetch_req_valid), 64'(0));
        step();
        check("one_inflight_b", 64'(ifetch_req_valid), 64'(0));
        send_rsp(2'd0, 1'b0);
        check("rsp_same_cycle", 64'(ifetch_req_valid), 64'(0));
        step();
        check_req("second", 2'd0, 32'h80000004, 4'hF, 44'd1);

        // Backpressure hold
        ifetch_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_req($sformatf("hold%0d", i), 2'd0, 32'h80000004, 4'hF, 44'd1);
        end
        ifetch_req_ready = 1'b1;
        step();
        check("accept_once", 64'(ifetch_req_valid), 64'(0));
        send_rsp(2'd0, 1'b0);
        step();
        check_req("after_bp", 2'd0, 32'h80000008, 4'hF, 44'd2);

        // Round-robin, park/resume, deactivate
        do_reset();
        reset       = 1'b1;
        spawn_valid = 1'b1;
        spawn_wid   = 2'd1;
        spawn_pc    = 32'h100;
        spawn_tmask = 4'h3;
        for (int k = 0; k < 17; k++) begin
            step();
            check_req($sformatf("rr%0d", k), t_wid[k], t_pc[k], t_tm[k], 44'(k));
            if (k == 15) check("active_w0_off", 64'(active_warps), 64'(4'b0110));
            if (k == 16) check("active_w1_off", 64'(active_warps), 64'(4'b0100));
            spawn_valid  = (k == 0);
            spawn_wid    = 2'd2;
            spawn_pc     = 32'h200;
            spawn_tmask  = 4'h3;
            rsp_valid    = 1'b1;
            rsp_wid      = t_wid[k];
            rsp_stall    = t_stall[k];
            resume_valid = t_res[k];
            resume_wid   = t_rwid[k];
            resume_pc    = t_rpc[k];
            resume_tmask = t_rtm[k];
        end
        step();
        spawn_valid  = 1'b0;
        rsp_valid    = 1'b0;
        rsp_stall    = 1'b0;
        resume_valid = 1'b0;
        check("all_off_valid",  64'(ifetch_req_valid), 64'(0));
        check("all_off_active", 64'(active_warps),     64'(0));
        check("all_off_busy",   64'(busy),             64'(0));
        step();
        check("all_off_idle", 64'(ifetch_req_valid), 64'(0));

        // Reset in the middle of a held request
        do_reset();
        reset       = 1'b1;
        spawn_valid = 1'b1;
        spawn_wid   = 2'd1;
        spawn_pc    = 32'h100;
        spawn_tmask = 4'h3;
        step();
        spawn_wid   = 2'd2;
        spawn_pc    = 32'h200;
        step();
        spawn_valid = 1'b0;
        step();
        ifetch_req_ready = 1'b0;
        check_req("pre_rst", 2'd2, 32'h200, 4'h3, 44'd2);
        step();
        step();
        check_req("pre_rst_hold", 2'd2, 32'h200, 4'h3, 44'd2);
        reset = 1'b0;
        step();
        check("mid_rst_valid",  64'(ifetch_req_valid), 64'(0));
        check("mid_rst_uuid",   64'(ifetch_req_uuid),  64'(0));
        check("mid_rst_wid",    64'(ifetch_req_wid),   64'(0));
        check("mid_rst_pc",     64'(ifetch_req_PC),    64'(0));
        check("mid_rst_tmask",  64'(ifetch_req_tmask), 64'(0));
        check("mid_rst_active", 64'(active_warps),     64'(4'b0001));
        reset            = 1'b1;
        ifetch_req_ready = 1'b1;
        step();
        check_req("post_rst", 2'd0, 32'h80000000, 4'hF, 44'd0);
        check("post_rst_active", 64'(active_warps), 64'(4'b0001));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ifetch_warp_sched.md
Name: ifetch_warp_sched

Overview:
- Per-core fetch scheduler that owns per-warp PC, thread mask and fetch state.
- Selects one eligible warp per cycle, round-robin, and drives the instruction-fetch request channel (valid/uuid/tmask/wid/PC, ready back).
- Each warp has at most one fetch in flight.
- Downstream decode/execute returns a completion per fetch and resumes warps that were parked on control flow.

Parameters:
- NUM_WARPS, 4, number of warps; NW_BITS = max(1, clog2(NUM_WARPS)).
- NUM_THREADS, 4, threads per warp (tmask width).
- XLEN, 32, PC width.
- UUID_BITS, 44, width of the per-request uuid counter.
- STARTUP_PC, 32'h80000000, PC loaded into warp 0 at reset.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low reset.
- spawn_valid  in  1  activate a warp.
- spawn_wid  in  NW_BITS  warp to activate.
- spawn_tmask  in  NUM_THREADS  initial mask.
- spawn_pc  in  XLEN  initial PC.
- rsp_valid  in  1  fetch for rsp_wid completed decode.
- rsp_wid  in  NW_BITS  warp of completed fetch.
- rsp_stall  in  1  1 = control-flow instruction; park warp until resume.
- resume_valid  in  1  un-park warp with new PC/mask.
- resume_wid  in  NW_BITS  warp to resume.
- resume_pc  in  XLEN  next PC.
- resume_tmask  in  NUM_THREADS  new mask; all-zero deactivates the warp.
- ifetch_req_valid  out  1  request valid.
- ifetch_req_uuid  out  UUID_BITS  request id.
- ifetch_req_tmask  out  NUM_THREADS  thread mask.
- ifetch_req_wid  out  NW_BITS  warp id.
- ifetch_req_PC  out  XLEN  fetch address.
- ifetch_req_ready  in  1  fetch unit accepts.
- active_warps  out  NUM_WARPS  per-warp active bit.
- busy  out  1  any warp active.

Behaviour:
- Per-warp state:
  - Fields: active, pending (fetch outstanding), parked, pc, tmask.
  - Eligible = active & ~pending & ~parked.
- Reset (reset==0 at a clk edge):
  - Warp 0 is loaded active with pc=STARTUP_PC and tmask all ones.
  - All other warps are inactive.
  - pending and parked are cleared for all warps.
  - uuid counter = 0; round-robin pointer = 0.
  - ifetch_req_valid = 0; all other request outputs = 0.
  - Reset mid-operation discards any held request and all in-flight state.
- Output register:
  - The request is registered.
  - Load condition: ~ifetch_req_valid | ifetch_req_ready.
  - On a load, the scheduler picks the first eligible warp at or after the pointer, modulo NUM_WARPS.
  - If one is found:
    - valid=1; outputs = that warp's pc/tmask/wid; uuid = counter.
    - Counter increments, wrapping at 2^UUID_BITS.
    - Warp pending<=1; warp pc<=pc+4, truncated to XLEN.
    - Pointer <= picked wid + 1, wrapping.
  - If none is found, valid<=0 and the pointer is unchanged.
- Backpressure: while valid & ~ready, all request outputs hold stable and no state advances for selection.
- Latency: an eligible warp appears on ifetch_req_* one cycle after becoming eligible, provided the output register can load.
- rsp_valid:
  - Clears pending[rsp_wid].
  - If rsp_stall=1, sets parked[rsp_wid].
  - A rsp for a non-pending warp is ignored.
- resume_valid:
  - Clears parked[resume_wid]; pc<=resume_pc; tmask<=resume_tmask.
  - If resume_tmask==0: active<=0 and parked<=0.
  - Resume of a non-parked warp still updates pc/tmask (redirect).
- spawn_valid:
  - Ignored if the warp is already active.
  - Otherwise sets active, pc, tmask and clears pending and parked.
  - A spawn with tmask 0 is ignored.
- Same-cycle events on one warp, in priority order:
  1. reset
  2. resume
  3. rsp
  4. spawn
  5. issue
- Same-cycle collision cases:
  - rsp with stall=1 and resume on the same warp → warp ends unparked with resume values.
  - A warp cannot be both issued and completed in one cycle, because issue requires ~pending.
  - Eligibility uses registered state only: a warp freed by rsp in cycle N is first eligible for selection in cycle N+1.
- Status outputs: active_warps and busy are direct state reads; they are 0 only if no warp is active.

Test Plan:
- Reset release, ready=1 → cycle after reset: valid=1, wid=0, PC=0x80000000, tmask=4'hF, uuid=0. No second request until rsp_valid wid=0 stall=0; then PC=0x80000004, uuid=1.
- Backpressure: hold ready=0 for 5 cycles with valid=1 → PC, wid and uuid are unchanged across all 5 cycles. Ready=1 → accepted once, and uuid advances by exactly 1.
- Round-robin: spawn warps 1 and 2 (PC 0x100 and 0x200, tmask 4'h3), return rsp stall=0 immediately → request order wid 0,1,2,0,1,2, each warp's PC stepping by 4.
- Park/resume: rsp wid=1 stall=1 → warp 1 is absent from the issue stream. Resume wid=1 PC=0x400 tmask=4'h1 → next warp-1 request has PC=0x400, tmask=4'h1.
- Deactivate: resume wid=0 with tmask=0 → active_warps bit 0 clears and warp 0 is never issued again. Deactivating all warps → busy=0, valid=0.
- Reset mid-op: assert reset while valid=1, ready=0, with warps 1–2 pending → all outputs 0, active_warps=4'b0001. First request after reset is wid 0, PC=0x80000000, uuid=0.
